// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable read mode (registered read or first-word-fall-through).
//
// Ports:
//   in_clk          clock, all state changes on the rising edge
//   in_rst          asynchronous active-low reset
//   in_data         write data, captured on an accepted write
//   in_w_en         write request
//   in_r_en         read request
//   o_data          read data (registered, or head word when FWFT=1)
//   o_full          count == DEPTH
//   o_empty         count == 0
//   o_almost_full   count >= AF_LEVEL
//   o_almost_empty  count <= AE_LEVEL
//   o_count         current occupancy, 0..DEPTH
//   o_overflow      one-cycle pulse after a rejected write request
//   o_underflow     one-cycle pulse after a rejected read request
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_w_en,
    input  logic                    in_r_en,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         w_ptr_reg;
    logic [AW-1:0]         r_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  rd_acc;
    logic                  wr_acc;

    // A full FIFO may still take a write when a read frees a slot in the
    // same cycle, so the write decision depends on the read decision.
    assign rd_acc = in_r_en && !o_empty;
    assign wr_acc = in_w_en && (!o_full || rd_acc);

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has its own reset so that stale data never leaks out of the
    // fall-through read port after a reset.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[w_ptr_reg] <= in_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr_reg <= w_ptr_reg + AW'(1);
            end
            if (rd_acc) begin
                r_ptr_reg <= r_ptr_reg + AW'(1);
            end
            count_reg     <= count_next;
            overflow_reg  <= in_w_en && !wr_acc;
            underflow_reg <= in_r_en && !rd_acc;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; only meaningful while not empty.
            assign o_data = mem[r_ptr_reg];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge in_clk or negedge in_rst) begin
                if (!in_rst) begin
                    data_reg <= '0;
                end else if (rd_acc) begin
                    data_reg <= mem[r_ptr_reg];
                end
            end

            assign o_data = data_reg;
        end
    endgenerate

    assign o_count        = count_reg;
    assign o_full         = (count_reg == CW'(DEPTH));
    assign o_empty        = (count_reg == '0);
    assign o_almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign o_almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign o_overflow     = overflow_reg;
    assign o_underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_param.sv
// Testbench for fifo_param: drives identical stimulus into a registered-read
// instance and a first-word-fall-through instance and checks both against a
// queue-based reference model, with directed sequences followed by random
// traffic and an asynchronous reset in the middle of a transfer.
module tb_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          w_en;
    logic          r_en;

    logic [DW-1:0] data0, data1;
    logic          full0, empty0, af0, ae0, ovf0, udf0;
    logic          full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0]    count0, count1;

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_reg (
        .in_clk(clk), .in_rst(rst_n), .in_data(in_data), .in_w_en(w_en), .in_r_en(r_en),
        .o_data(data0), .o_full(full0), .o_empty(empty0), .o_almost_full(af0),
        .o_almost_empty(ae0), .o_count(count0), .o_overflow(ovf0), .o_underflow(udf0)
    );

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
        .in_clk(clk), .in_rst(rst_n), .in_data(in_data), .in_w_en(w_en), .in_r_en(r_en),
        .o_data(data1), .o_full(full1), .o_empty(empty1), .o_almost_full(af1),
        .o_almost_empty(ae1), .o_count(count1), .o_overflow(ovf1), .o_underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_data0;
    logic          exp_ovf;
    logic          exp_udf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        int sz;
        sz = model_q.size();
        chk({ph, " count"},     64'(count0), 64'(sz));
        chk({ph, " full"},      64'(full0),  64'(sz == DEPTH));
        chk({ph, " empty"},     64'(empty0), 64'(sz == 0));
        chk({ph, " afull"},     64'(af0),    64'(sz >= AF));
        chk({ph, " aempty"},    64'(ae0),    64'(sz <= AE));
        chk({ph, " overflow"},  64'(ovf0),   64'(exp_ovf));
        chk({ph, " underflow"}, 64'(udf0),   64'(exp_udf));
        chk({ph, " data"},      64'(data0),  64'(exp_data0));
        chk({ph, " f_count"},   64'(count1), 64'(sz));
        chk({ph, " f_flags"},   64'({full1, empty1, af1, ae1, ovf1, udf1}),
            64'({sz == DEPTH, sz == 0, sz >= AF, sz <= AE, exp_ovf, exp_udf}));
        if (sz > 0) begin
            chk({ph, " f_head"}, 64'(data1), 64'(model_q[0]));
        end
    endtask

    // One clock cycle of traffic; the model applies the acceptance rules to
    // the occupancy seen before the edge.
    task automatic step(input string ph, input logic w, input logic r, input logic [DW-1:0] d);
        logic rd, wr;
        w_en    = w;
        r_en    = r;
        in_data = d;
        @(posedge clk);
        #1;
        rd = r && (model_q.size() > 0);
        wr = w && ((model_q.size() < DEPTH) || rd);
        if (rd) exp_data0 = model_q.pop_front();
        if (wr) model_q.push_back(d);
        exp_ovf = w && !wr;
        exp_udf = r && !rd;
        $display("[TB] %s w=%0b r=%0b d=%0h count=%0d data=%0h", ph, w, r, d, count0, data0);
        check_all(ph);
    endtask

    // Assert reset between edges and check the outputs before any edge.
    task automatic async_reset(input string ph);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        w_en  = 1'b1;
        r_en  = 1'b1;
        #1;
        model_q.delete();
        exp_data0 = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        check_all({ph, "_async"});
        @(posedge clk);
        #1;
        check_all({ph, "_held"});
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        in_data = '0;
        exp_data0 = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Registered-read ordering and underflow with data hold.
        step("order", 1, 0, 1);
        step("order", 1, 0, 2);
        step("order", 0, 1, 0);
        step("order", 0, 1, 0);
        step("order", 0, 1, 0);
        step("order", 0, 0, 0);

        // Move pointers to 4, then fill across the wrap point.
        step("adv", 1, 0, 32'h55);
        step("adv", 1, 0, 32'h66);
        step("adv", 0, 1, 0);
        step("adv", 0, 1, 0);
        for (int i = 5; i <= 12; i++) step("fill", 1, 0, DW'(i));
        step("ovf", 1, 0, 13);
        step("full_rw", 1, 1, 99);
        for (int i = 0; i < 8; i++) step("drain", 0, 1, 0);
        step("empty_rw", 1, 1, 7);
        step("drain1", 0, 1, 0);

        // Thresholds on the way up and down.
        for (int i = 0; i < 8; i++) step("thr_up", 1, 0, DW'(100 + i));
        for (int i = 0; i < 8; i++) step("thr_dn", 0, 1, 0);

        // Mid-transfer reset; first write afterwards must land at the head.
        step("pre_rst", 1, 0, 32'hdead);
        step("pre_rst", 1, 1, 32'hbeef);
        async_reset("midrst");
        step("post_rst", 1, 0, 32'hA);
        step("post_rst", 0, 0, 0);
        step("post_rst", 1, 0, 32'hB);
        step("post_rst", 0, 1, 0);
        step("post_rst", 0, 1, 0);

        // Random traffic with varying write/read bias.
        for (int p = 0; p < 4; p++) begin
            int pw, pr;
            pw = (p == 0) ? 75 : (p == 1) ? 25 : (p == 2) ? 50 : 90;
            pr = (p == 0) ? 25 : (p == 1) ? 75 : (p == 2) ? 50 : 90;
            for (int i = 0; i < 120; i++) begin
                step("rand", $urandom_range(99) < pw, $urandom_range(99) < pr, $urandom);
            end
            if (p == 2) async_reset("randrst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous single-clock FIFO; next generation of the fixed 32x8 register-file FIFO. Adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, overflow and underflow pulses, and a selectable first-word-fall-through read mode. Used as the general buffering primitive between producer and consumer blocks in one clock domain.

Parameters:
DATA_WIDTH, 32, bits per word
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, o_almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, o_almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
in_clk  input  1  clock; all state changes on rising edge
in_rst  input  1  asynchronous, active-low reset
in_data  input  DATA_WIDTH  write data; sampled only on an accepted write
in_w_en  input  1  write request
in_r_en  input  1  read request
o_data  output  DATA_WIDTH  read data
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0
o_almost_full  output  1  count >= AF_LEVEL
o_almost_empty  output  1  count <= AE_LEVEL
o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_overflow  output  1  one-cycle pulse: write request rejected
o_underflow  output  1  one-cycle pulse: read request rejected

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a registered count.
- Accepted read (rd_acc) = in_r_en && !o_empty.
- Accepted write (wr_acc) = in_w_en && (!o_full || rd_acc). Write is allowed when full only if a read is accepted in the same cycle.
- On wr_acc: mem[w_ptr] <= in_data, w_ptr++. On rd_acc: r_ptr++.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted or neither is.
- All flags are combinational decodes of the registered count. They change in the cycle after the causing edge.
- Read path, FWFT=0: o_data <= mem[r_ptr] on rd_acc, otherwise holds. Data appears one cycle after the read edge.
- Read path, FWFT=1: o_data = mem[r_ptr] combinationally. The head word is valid whenever o_empty=0; rd_acc pops it.
- Empty FIFO with in_w_en=1 and in_r_en=1: write accepted, read rejected, o_underflow pulses, count becomes 1.
- Full FIFO with both requests: both accepted; count stays DEPTH, o_full stays 1, no overflow.
- o_overflow <= in_w_en && !wr_acc. o_underflow <= in_r_en && !rd_acc. Both are registered pulses, high for exactly one cycle per rejected request, and are not sticky.
- Reset (in_rst=0, asynchronous, immediate):
  - pointers, count and every mem entry go to 0;
  - o_data=0, o_empty=1, o_almost_empty=1;
  - o_full=0, o_almost_full=0, o_count=0, o_overflow=0, o_underflow=0.
- Reset asserted mid-transfer discards all contents. First write after deassertion lands in mem[0].
- Reset deassertion is synchronised externally. No requests are accepted while in_rst=0.
- in_data and request inputs are don't-care during reset.

Test Plan:
- Reset: drive in_rst=0 mid-stream -> o_empty=1, o_count=0, o_data=0, o_full=0 immediately, with no clock edge needed.
- FWFT=0 ordering: write 1,2, then read twice -> o_data=1 one cycle after the first read edge, then 2. o_empty=1 after the second read. Further in_r_en -> o_underflow pulses one cycle and o_data stays 2.
- Wrap and full: advance pointers by 4, then write 5..12 -> o_full=1 and o_count=8 after the 8th write. Write 13 -> o_overflow pulses and 13 is dropped. Drain -> 5,6,...,12 in order, o_empty=1.
- Simultaneous access:
  - full plus read and write of 99 -> count stays 8, no overflow; 99 is read last after the drain;
  - empty plus read and write of 7 -> o_underflow=1, o_count=1.
- Thresholds (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
  - o_almost_empty deasserts after the 3rd write;
  - o_almost_full asserts after the 6th write;
  - both revert at the same counts while draining.
- FWFT=1: write 0xA -> o_data=0xA the cycle after the write with no read. Write 0xB, then read once -> o_data=0xB the next cycle.
